// File: rtl/axi4lite_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// axi4lite_req_arbiter_if
//
// Bundles every bus signal of the two-requester AXI4-Lite command arbiter:
// the two requester command ports (req0_*, req1_*) and the master command
// port (m_*).
//
// Modports:
//   slave  - the arbiter's view: requester commands and master completion in,
//            requester accept/response and master start/address/data out.
//   master - the environment's view (requesters plus master), mirror image.
//
// Parameters:
//   ADDR_WIDTH - address width of requester and master address buses
//   DATA_WIDTH - width of write and read data buses
// -----------------------------------------------------------------------------
interface axi4lite_req_arbiter_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
);
    // Requester 0
    logic                  req0_valid;
    logic                  req0_write;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_ready;
    logic                  req0_done;
    logic                  req0_err;
    logic [DATA_WIDTH-1:0] req0_rdata;

    // Requester 1
    logic                  req1_valid;
    logic                  req1_write;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_ready;
    logic                  req1_done;
    logic                  req1_err;
    logic [DATA_WIDTH-1:0] req1_rdata;

    // Master command port
    logic                  m_start_write;
    logic                  m_start_read;
    logic [ADDR_WIDTH-1:0] m_write_addr;
    logic [DATA_WIDTH-1:0] m_write_data;
    logic [ADDR_WIDTH-1:0] m_read_addr;
    logic [DATA_WIDTH-1:0] m_read_data;
    logic                  m_done;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, req0_done, req0_err, req0_rdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, req1_done, req1_err, req1_rdata,
        output m_start_write, m_start_read, m_write_addr, m_write_data, m_read_addr,
        input  m_read_data, m_done
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, req0_done, req0_err, req0_rdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, req1_done, req1_err, req1_rdata,
        input  m_start_write, m_start_read, m_write_addr, m_write_data, m_read_addr,
        output m_read_data, m_done
    );
endinterface

// File: rtl/axi4lite_req_arbiter.sv
// -----------------------------------------------------------------------------
// axi4lite_req_arbiter
//
// Round-robin arbiter and sequencer placing two requesters in front of a single
// AXI4-Lite master command port. One transaction is in flight at a time: a
// request is accepted in IDLE, issued as a single start pulse in ISSUE, its
// completion (or watchdog expiry) awaited in WAIT, and reported back to the
// granted requester as a one-cycle done pulse in RESP.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - axi4lite_req_arbiter_if.slave: req0_*/req1_* requester ports and
//           m_* master command port
//
// Parameters:
//   ADDR_WIDTH, DATA_WIDTH - bus widths, must match the interface instance
//   TIMEOUT                - WAIT cycles before forced error completion (1..255)
// -----------------------------------------------------------------------------
module axi4lite_req_arbiter #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    axi4lite_req_arbiter_if.slave       bus
);

    localparam logic [7:0] TIMEOUT_8 = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  start;

    logic                  last_grant;   // requester granted most recently
    logic                  grant_id;     // requester owning the transaction in flight
    logic                  cmd_write;
    logic                  err;
    logic [7:0]            wdog;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_WIDTH-1:0] raddr_q;

    // ------------------------------------------------------------------
    // Arbitration: a lone requester wins; on a tie the one that was not
    // granted last time wins.
    // ------------------------------------------------------------------
    logic                  any_valid;
    logic                  grant_sel;
    logic                  accept;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  wdog_hit;

    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign grant_sel = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
    assign accept    = (state == IDLE) & any_valid;

    assign sel_write = grant_sel ? bus.req1_write : bus.req0_write;
    assign sel_addr  = grant_sel ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = grant_sel ? bus.req1_wdata : bus.req0_wdata;

    // The count reaches TIMEOUT on this cycle's increment.
    assign wdog_hit  = (wdog + 8'd1) == TIMEOUT_8;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values present before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and start strobe
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default at the top, so no branch can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_valid) state_next = ISSUE;
            end
            ISSUE: begin
                // A done level left over from the previous transaction must
                // drop before the next command is started.
                if (!bus.m_done) begin
                    start      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.m_done || wdog_hit) state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command capture, watchdog and response datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;           // requester 0 wins the first tie
            grant_id   <= 1'b0;
            cmd_write  <= 1'b0;
            err        <= 1'b0;
            wdog       <= 8'd0;
            rdata0     <= '0;
            rdata1     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            raddr_q    <= '0;
        end else begin
            if (accept) begin
                grant_id   <= grant_sel;
                last_grant <= grant_sel;
                cmd_write  <= sel_write;
                // The unused direction's buses are zeroed for the whole
                // transaction; they keep the values through the next IDLE.
                if (sel_write) begin
                    waddr_q <= sel_addr;
                    wdata_q <= sel_wdata;
                    raddr_q <= '0;
                end else begin
                    waddr_q <= '0;
                    wdata_q <= '0;
                    raddr_q <= sel_addr;
                end
            end

            if (start) begin
                wdog <= 8'd0;
            end

            if (state == WAIT) begin
                if (bus.m_done) begin
                    err <= 1'b0;
                    if (!cmd_write) begin
                        if (grant_id) rdata1 <= bus.m_read_data;
                        else          rdata0 <= bus.m_read_data;
                    end
                end else begin
                    wdog <= wdog + 8'd1;
                    if (wdog_hit) err <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic resp;
    assign resp = (state == RESP);

    assign bus.req0_ready    = (state == IDLE) & bus.req0_valid & ~grant_sel;
    assign bus.req1_ready    = (state == IDLE) & bus.req1_valid &  grant_sel;
    assign bus.req0_done     = resp & ~grant_id;
    assign bus.req1_done     = resp &  grant_id;
    assign bus.req0_err      = resp & ~grant_id & err;
    assign bus.req1_err      = resp &  grant_id & err;
    assign bus.req0_rdata    = rdata0;
    assign bus.req1_rdata    = rdata1;

    assign bus.m_start_write = start &  cmd_write;
    assign bus.m_start_read  = start & ~cmd_write;
    assign bus.m_write_addr  = waddr_q;
    assign bus.m_write_data  = wdata_q;
    assign bus.m_read_addr   = raddr_q;

endmodule

// File: tb/tb_axi4lite_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi4lite_req_arbiter
//
// Self-checking bench for axi4lite_req_arbiter. Requester drivers present
// queued commands, a master responder answers start pulses after a chosen
// delay from a small memory, and a monitor logs accepts, start pulses and
// done pulses. Each test compares those logs against a transaction-level
// model: grant order from the round-robin rule, read data from a shadow of
// the master memory, and cycle distances from the documented latencies.
// -----------------------------------------------------------------------------
module tb_axi4lite_req_arbiter;

    localparam int AW      = 2;
    localparam int DW      = 8;
    localparam int TIMEOUT = 5;

    typedef struct {
        bit            write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct {
        int   id;
        cmd_t c;
    } exp_t;

    typedef struct {
        int id;
        int cyc;
    } acc_t;

    typedef struct {
        bit            write;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] raddr;
        int            d;
        int            cyc;
    } st_t;

    typedef struct {
        int            id;
        bit            err;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        int            cyc;
    } dn_t;

    logic clk;
    logic rst_n;

    axi4lite_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4lite_req_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Environment state
    int   cyc = 0;
    cmd_t rq0[$];
    cmd_t rq1[$];
    acc_t acc_q[$];
    st_t  start_q[$];
    st_t  resp_q[$];
    dn_t  done_q[$];
    int   outstanding = 0;
    int   overlap_cnt = 0;
    int   dual_cnt    = 0;
    int   fixed_delay = 0;
    bit   stuck_low   = 0;
    bit   hold_done   = 0;

    // Model state
    cmd_t          p0[$];
    cmd_t          p1[$];
    exp_t          exp_q[$];
    int            m_lg = 1;
    logic [DW-1:0] exp_rd[2];
    logic [DW-1:0] ref_mem[4];
    int            ba, bs, bd, be;

    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] init_val(input int a);
        return 8'(8'hA5 ^ (a * 37));
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Requester drivers: present the head of each command queue until accepted.
    initial begin : drv
        bit a0, a1;
        bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
        forever begin
            @(negedge clk);
            a0 = rst_n & bus.req0_valid & bus.req0_ready;
            a1 = rst_n & bus.req1_valid & bus.req1_ready;
            @(posedge clk);
            #1;
            if (a0 && rst_n && rq0.size() > 0) void'(rq0.pop_front());
            if (a1 && rst_n && rq1.size() > 0) void'(rq1.pop_front());
            if (rq0.size() > 0) begin
                bus.req0_valid = 1'b1;
                bus.req0_write = rq0[0].write;
                bus.req0_addr  = rq0[0].addr;
                bus.req0_wdata = rq0[0].wdata;
            end else begin
                bus.req0_valid = 1'b0;
                bus.req0_write = 1'($urandom);
                bus.req0_addr  = AW'($urandom);
                bus.req0_wdata = DW'($urandom);
            end
            if (rq1.size() > 0) begin
                bus.req1_valid = 1'b1;
                bus.req1_write = rq1[0].write;
                bus.req1_addr  = rq1[0].addr;
                bus.req1_wdata = rq1[0].wdata;
            end else begin
                bus.req1_valid = 1'b0;
                bus.req1_write = 1'($urandom);
                bus.req1_addr  = AW'($urandom);
                bus.req1_wdata = DW'($urandom);
            end
        end
    end

    // Monitor: logs accepts, start pulses and done pulses.
    always @(negedge clk) begin
        st_t s;
        dn_t d;
        acc_t a;
        if (!rst_n) begin
            outstanding = 0;
        end else begin
            if (bus.req0_valid && bus.req0_ready) begin
                a.id = 0; a.cyc = cyc; acc_q.push_back(a);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                a.id = 1; a.cyc = cyc; acc_q.push_back(a);
            end
            if (bus.m_start_write || bus.m_start_read) begin
                if (bus.m_start_write && bus.m_start_read) dual_cnt++;
                if (outstanding != 0) overlap_cnt++;
                outstanding = 1;
                s.write = bus.m_start_write;
                s.waddr = bus.m_write_addr;
                s.wdata = bus.m_write_data;
                s.raddr = bus.m_read_addr;
                s.d     = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(4, 1));
                s.cyc   = cyc;
                start_q.push_back(s);
                resp_q.push_back(s);
            end
            if (bus.req0_done || bus.req1_done) begin
                if (bus.req0_done && bus.req1_done) dual_cnt++;
                outstanding = 0;
                d.id  = bus.req1_done ? 1 : 0;
                d.err = bus.req1_done ? bus.req1_err : bus.req0_err;
                d.rd0 = bus.req0_rdata;
                d.rd1 = bus.req1_rdata;
                d.cyc = cyc;
                done_q.push_back(d);
            end
        end
    end

    // Master responder: raises m_done d cycles after the start pulse.
    initial begin : responder
        logic [DW-1:0] slave_mem[4];
        st_t cur;
        bit  active;
        int  cd;
        active = 1'b0;
        cd     = 0;
        for (int a = 0; a < 4; a++) slave_mem[a] = init_val(a);
        bus.m_done      = 1'b0;
        bus.m_read_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                active = 1'b0;
                resp_q.delete();
                bus.m_done = 1'b0;
            end else begin
                if (resp_q.size() > 0) begin
                    cur    = resp_q.pop_front();
                    active = !stuck_low;
                    cd     = cur.d;
                    if (cur.write) slave_mem[cur.waddr] = cur.wdata;
                end
                if (active) begin
                    if (cd <= 1) begin
                        bus.m_done      = 1'b1;
                        bus.m_read_data = cur.write ? DW'($urandom) : slave_mem[cur.raddr];
                        active          = 1'b0;
                    end else begin
                        cd--;
                    end
                end else if (!hold_done) begin
                    bus.m_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit reached at cycle %0d", cyc);
        $fatal(1, "simulation time limit");
    end

    // ------------------------------------------------------------------
    // Model helpers
    // ------------------------------------------------------------------
    task automatic mark();
        ba = acc_q.size();
        bs = start_q.size();
        bd = done_q.size();
    endtask

    // Grant order from the round-robin rule, computed per transaction.
    task automatic plan();
        int a = 0;
        int b = 0;
        int g;
        exp_t e;
        be = exp_q.size();
        while (a < p0.size() || b < p1.size()) begin
            if (a < p0.size() && b < p1.size()) g = 1 - m_lg;
            else if (a < p0.size())             g = 0;
            else                                g = 1;
            m_lg = g;
            e.id = g;
            if (g == 1) begin e.c = p1[b]; b++; end
            else        begin e.c = p0[a]; a++; end
            exp_q.push_back(e);
        end
        foreach (p0[i]) rq0.push_back(p0[i]);
        foreach (p1[i]) rq1.push_back(p1[i]);
        p0.delete();
        p1.delete();
    endtask

    function automatic cmd_t mk(input bit w, input int addr, input int wdata);
        cmd_t c;
        c.write = w;
        c.addr  = AW'(addr);
        c.wdata = DW'(wdata);
        return c;
    endfunction

    task automatic wait_done(input int n, input int budget, input string tag);
        int t = 0;
        while (done_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done_q.size() < n) begin
            errors++;
            $display("FAIL %s_wait done count %0d required %0d", tag, done_q.size(), n);
        end
    endtask

    // Compares logged transactions [base, base+n) against the model.
    task automatic score(input int n, input bit to_mode, input bit lat, input string tag);
        acc_t a;
        st_t  s;
        dn_t  d;
        exp_t e;
        int   want_lat;
        checks++;
        if (acc_q.size() - ba < n || start_q.size() - bs < n || done_q.size() - bd < n) begin
            errors++;
            $display("FAIL %s_counts acc %0d start %0d done %0d required %0d", tag,
                     acc_q.size() - ba, start_q.size() - bs, done_q.size() - bd, n);
            return;
        end
        for (int k = 0; k < n; k++) begin
            a = acc_q[ba+k];
            s = start_q[bs+k];
            d = done_q[bd+k];
            e = exp_q[be+k];

            checks++;
            if (a.id !== e.id) begin
                errors++;
                $display("FAIL %s_grant[%0d] got %0d required %0d", tag, k, a.id, e.id);
            end
            checks++;
            if (s.write !== e.c.write) begin
                errors++;
                $display("FAIL %s_start_kind[%0d] got %0d required %0d", tag, k, s.write, e.c.write);
            end
            checks++;
            if (e.c.write) begin
                if (s.waddr !== e.c.addr || s.wdata !== e.c.wdata || s.raddr !== '0) begin
                    errors++;
                    $display("FAIL %s_wr_bus[%0d] got waddr %0h wdata %0h raddr %0h required %0h %0h 0",
                             tag, k, s.waddr, s.wdata, s.raddr, e.c.addr, e.c.wdata);
                end
            end else begin
                if (s.raddr !== e.c.addr || s.waddr !== '0 || s.wdata !== '0) begin
                    errors++;
                    $display("FAIL %s_rd_bus[%0d] got raddr %0h waddr %0h wdata %0h required %0h 0 0",
                             tag, k, s.raddr, s.waddr, s.wdata, e.c.addr);
                end
            end
            if (lat) begin
                checks++;
                if (s.cyc - a.cyc !== 1) begin
                    errors++;
                    $display("FAIL %s_accept_to_start[%0d] got %0d required 1", tag, k, s.cyc - a.cyc);
                end
            end
            checks++;
            if (d.id !== e.id || d.err !== to_mode) begin
                errors++;
                $display("FAIL %s_done[%0d] got id %0d err %0d required id %0d err %0d",
                         tag, k, d.id, d.err, e.id, to_mode);
            end
            want_lat = to_mode ? TIMEOUT + 1 : s.d + 1;
            checks++;
            if (d.cyc - s.cyc !== want_lat) begin
                errors++;
                $display("FAIL %s_start_to_done[%0d] got %0d required %0d", tag, k, d.cyc - s.cyc, want_lat);
            end

            if (e.c.write)     ref_mem[e.c.addr] = e.c.wdata;
            else if (!to_mode) exp_rd[e.id] = ref_mem[e.c.addr];

            checks++;
            if (d.rd0 !== exp_rd[0] || d.rd1 !== exp_rd[1]) begin
                errors++;
                $display("FAIL %s_rdata[%0d] got %0h %0h required %0h %0h",
                         tag, k, d.rd0, d.rd1, exp_rd[0], exp_rd[1]);
            end
        end
        checks++;
        if (overlap_cnt !== 0 || dual_cnt !== 0) begin
            errors++;
            $display("FAIL %s_single_outstanding overlap %0d dual %0d required 0 0", tag, overlap_cnt, dual_cnt);
        end
    endtask

    function automatic logic [35:0] all_outs();
        return {bus.req0_ready, bus.req1_ready, bus.req0_done, bus.req1_done,
                bus.req0_err, bus.req1_err, bus.m_start_write, bus.m_start_read,
                bus.m_write_addr, bus.m_write_data, bus.m_read_addr,
                bus.req0_rdata, bus.req1_rdata};
    endfunction

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [35:0] o;
        rst_n = 1'b0;
        #12;
        o = all_outs();
        checks++;
        if (o !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs_in_reset got %0h required 0", o);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        o = all_outs();
        checks++;
        if (o !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs_after_release got %0h required 0", o);
        end
    endtask

    task automatic test_write();
        mark();
        fixed_delay = 3;
        p0.push_back(mk(1'b1, 2, 8'h04));
        plan();
        wait_done(bd + 1, 40, "write");
        checks++;
        if (start_q.size() - bs !== 1) begin
            errors++;
            $display("FAIL write_pulse_count got %0d required 1", start_q.size() - bs);
        end
        score(1, 1'b0, 1'b1, "write");
    endtask

    task automatic test_read();
        mark();
        fixed_delay = 2;
        p1.push_back(mk(1'b0, 2, 0));
        plan();
        wait_done(bd + 1, 40, "read");
        score(1, 1'b0, 1'b1, "read");
        repeat (3) @(negedge clk);
        checks++;
        if (bus.req1_rdata !== 8'h04 || bus.req0_rdata !== 8'h00) begin
            errors++;
            $display("FAIL read_rdata_held got %0h %0h required 0 4", bus.req0_rdata, bus.req1_rdata);
        end
    endtask

    task automatic test_round_robin();
        mark();
        fixed_delay = 0;
        for (int i = 0; i < 2; i++) begin
            p0.push_back(mk(1'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(255, 0))));
            p1.push_back(mk(1'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(255, 0))));
        end
        plan();
        wait_done(bd + 4, 100, "rr");
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (acc_q.size() <= ba + k || acc_q[ba+k].id !== k % 2) begin
                errors++;
                $display("FAIL rr_order[%0d] got %0d required %0d", k,
                         (acc_q.size() > ba + k) ? acc_q[ba+k].id : -1, k % 2);
            end
        end
        score(4, 1'b0, 1'b1, "rr");
    endtask

    task automatic test_stale_done();
        int rel;
        mark();
        fixed_delay = 2;
        hold_done   = 1'b1;
        p0.push_back(mk(1'b1, 1, 8'h5A));
        p0.push_back(mk(1'b0, 1, 0));
        plan();
        wait_done(bd + 1, 40, "stale_first");
        repeat (6) @(negedge clk);
        checks++;
        if (start_q.size() - bs !== 1 || done_q.size() - bd !== 1) begin
            errors++;
            $display("FAIL stale_held got starts %0d dones %0d required 1 1",
                     start_q.size() - bs, done_q.size() - bd);
        end
        hold_done = 1'b0;
        rel = cyc;
        wait_done(bd + 2, 40, "stale_second");
        checks++;
        if (start_q.size() - bs < 2 || start_q[bs+1].cyc !== rel + 1) begin
            errors++;
            $display("FAIL stale_start_cycle got %0d required %0d",
                     (start_q.size() - bs >= 2) ? start_q[bs+1].cyc : -1, rel + 1);
        end
        score(2, 1'b0, 1'b0, "stale");
    endtask

    task automatic test_timeout();
        mark();
        fixed_delay = 1;
        stuck_low   = 1'b1;
        p0.push_back(mk(1'b0, 3, 0));
        plan();
        wait_done(bd + 1, 40, "timeout");
        score(1, 1'b1, 1'b1, "timeout");
        stuck_low = 1'b0;
        mark();
        p1.push_back(mk(1'b1, 3, 8'hC3));
        plan();
        wait_done(bd + 1, 40, "after_timeout");
        score(1, 1'b0, 1'b1, "after_timeout");
    endtask

    task automatic test_reset_mid();
        logic [35:0] o;
        int t = 0;
        mark();
        stuck_low = 1'b1;
        p1.push_back(mk(1'b0, 2, 0));
        plan();
        while (start_q.size() <= bs && t < 40) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (start_q.size() <= bs) begin
            errors++;
            $display("FAIL reset_mid_no_start got 0 starts required 1");
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        o = all_outs();
        checks++;
        if (o !== 36'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %0h required 0", o);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_q.size() !== bd) begin
            errors++;
            $display("FAIL reset_mid_done_pulse got %0d required %0d", done_q.size(), bd);
        end
        m_lg      = 1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        stuck_low = 1'b0;
        #2 rst_n = 1'b1;
        mark();
        fixed_delay = 0;
        p0.push_back(mk(1'b0, 0, 0));
        p1.push_back(mk(1'b1, 0, 8'h77));
        plan();
        wait_done(bd + 2, 60, "reset_tie");
        checks++;
        if (acc_q.size() <= ba || acc_q[ba].id !== 0) begin
            errors++;
            $display("FAIL reset_tie_first_grant got %0d required 0",
                     (acc_q.size() > ba) ? acc_q[ba].id : -1);
        end
        score(2, 1'b0, 1'b1, "reset_tie");
    endtask

    task automatic test_random();
        fixed_delay = 0;
        for (int batch = 0; batch < 3; batch++) begin
            mark();
            for (int j = 0; j < 10; j++) begin
                if ($urandom_range(1, 0) == 0)
                    p0.push_back(mk(1'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(255, 0))));
                else
                    p1.push_back(mk(1'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(255, 0))));
            end
            plan();
            wait_done(bd + 10, 300, "random");
            score(10, 1'b0, 1'b1, "random");
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        for (int a = 0; a < 4; a++) ref_mem[a] = init_val(a);
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_stale_done();
        test_timeout();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
